// File: rtl/uart_rx_fifo_if.sv
// CPU-side read bus of the UART receiver FIFO.
// The CPU (master) pops, flushes and clears overrun; the receiver (slave) answers.
interface uart_rx_fifo_if #(
  parameter int MAX_WORD_LEN = 9,
  parameter int FIFO_DEPTH   = 16
);
  logic                          rd;
  logic                          flush;
  logic                          ovr_clr;
  logic [MAX_WORD_LEN-1:0]       data;
  logic                          rx_frameerror;
  logic                          rx_parityerror;
  logic                          rx_break;
  logic                          charreceived;
  logic                          full;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          receiveoverrun;

  modport master (
    output rd, flush, ovr_clr,
    input  data, rx_frameerror, rx_parityerror, rx_break,
    input  charreceived, full, level, receiveoverrun
  );

  modport slave (
    input  rd, flush, ovr_clr,
    output data, rx_frameerror, rx_parityerror, rx_break,
    output charreceived, full, level, receiveoverrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote sampling,
// parity/stop/break checking and a show-ahead receive FIFO.
module uart_rx_fifo #(
  parameter int MAX_WORD_LEN = 9,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rxen,
  input  logic       rx,
  input  logic [3:0] wordlen,
  input  logic [1:0] parity,
  input  logic       stopbits,
  input  logic       u2x,
  output logic       busy,
  uart_rx_fifo_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = MAX_WORD_LEN + 3;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t r_state, w_next;

  logic                    r_sync1, r_sync2, r_prev;
  logic [CW-1:0]           r_cnt;
  logic                    r_v0, r_v1;
  logic [3:0]              r_idx;
  logic [MAX_WORD_LEN-1:0] r_data;
  logic                    r_ferr, r_perr, r_allz;

  logic [CW-1:0] w_half, w_m0, w_m2, w_lastv;
  logic          w_mid0, w_mid1, w_mid2, w_last;
  logic          w_s, w_maj, w_par, w_push;
  logic          w_ferr, w_brk;
  logic [3:0]    w_wl, w_wlm1;

  assign w_s     = r_sync2;
  assign w_half  = u2x ? CW'(OVERSAMPLE/4) : CW'(OVERSAMPLE/2);
  assign w_lastv = u2x ? CW'(OVERSAMPLE/2-1) : CW'(OVERSAMPLE-1);
  assign w_m0    = w_half - 1'b1;
  assign w_m2    = w_half + 1'b1;
  assign w_mid0  = baud_tick && r_cnt == w_m0;
  assign w_mid1  = baud_tick && r_cnt == w_half;
  assign w_mid2  = baud_tick && r_cnt == w_m2;
  assign w_last  = baud_tick && r_cnt == w_lastv;
  assign w_maj   = (r_v0 & r_v1) | (r_v0 & w_s) | (r_v1 & w_s);
  assign w_par   = parity == 2'd1 || parity == 2'd2;
  assign w_wl    = (wordlen >= 4'd5 &&
                    wordlen <= 4'(MAX_WORD_LEN)) ? wordlen : 4'd8;
  assign w_wlm1  = w_wl - 4'd1;
  assign busy    = r_state != IDLE;

  // Flags for the pushed entry include the stop sample taken this tick
  assign w_ferr = r_ferr | ~w_maj;
  assign w_brk  = (r_state == STOP1) ? (r_allz & ~w_maj) : r_allz;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    if (!rxen) begin
      w_next = IDLE;
    end else if (baud_tick) begin
      unique case (r_state)
        IDLE:
          if (r_prev && !w_s) w_next = START;
        START:
          if (w_mid2 && w_maj) w_next = IDLE;
          else if (w_last)     w_next = DATA;
        DATA:
          if (w_last && r_idx == w_wlm1)
            w_next = w_par ? PARITY : STOP1;
        PARITY:
          if (w_last) w_next = STOP1;
        STOP1:
          if (stopbits) begin
            if (w_last) w_next = STOP2;
          end else if (w_mid2) begin
            w_push = 1'b1;
            w_next = IDLE;
          end
        STOP2:
          if (w_mid2) begin
            w_push = 1'b1;
            w_next = IDLE;
          end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_v0    <= 1'b1;
      r_v1    <= 1'b1;
      r_idx   <= '0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_allz  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (baud_tick) r_prev <= w_s;
      if (w_mid0) r_v0 <= w_s;
      if (w_mid1) r_v1 <= w_s;
      if (!rxen) begin
        r_cnt <= '0;
      end else if (baud_tick) begin
        if (r_state == IDLE)
          r_cnt <= (w_next == START) ? CW'(1) : '0;
        else if (w_next == IDLE || w_last)
          r_cnt <= '0;
        else
          r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == IDLE) begin
        r_idx  <= '0;
        r_data <= '0;
        r_ferr <= 1'b0;
        r_perr <= 1'b0;
        r_allz <= 1'b1;
      end else if (rxen) begin
        if (w_mid2) begin
          unique case (r_state)
            DATA: begin
              if (r_idx < 4'(MAX_WORD_LEN))
                r_data[r_idx] <= w_maj;
              r_allz <= r_allz & ~w_maj;
            end
            PARITY: begin
              r_perr <= (parity == 2'd1) ?
                        ((^r_data) != w_maj) :
                        ((^r_data) == w_maj);
              r_allz <= r_allz & ~w_maj;
            end
            STOP1: begin
              r_ferr <= w_ferr;
              r_allz <= r_allz & ~w_maj;
            end
            STOP2: r_ferr <= w_ferr;
            default: ;
          endcase
        end
        if (r_state == DATA && w_last) r_idx <= r_idx + 4'd1;
      end
    end
  end

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_level;
  logic          r_ovr;
  logic          w_nempty, w_full, w_rd, w_wr, w_ovf;
  logic [EW-1:0] w_head;

  assign w_nempty = r_level != '0;
  assign w_full   = r_level == LW'(FIFO_DEPTH);
  assign w_rd     = bus.rd & w_nempty;
  // A pop in the same clk frees the slot the push needs
  assign w_wr     = w_push & (~w_full | w_rd);
  assign w_ovf    = w_push & w_full & ~w_rd & ~bus.flush;
  assign w_head   = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_wr && !bus.flush)
      r_mem[r_wp] <= {w_brk, r_perr, w_ferr, r_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_ovf)            r_ovr <= 1'b1;
      else if (bus.ovr_clr) r_ovr <= 1'b0;
      if (bus.flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_level <= '0;
      end else begin
        if (w_wr) r_wp <= r_wp + 1'b1;
        if (w_rd) r_rp <= r_rp + 1'b1;
        if (w_wr && !w_rd)      r_level <= r_level + 1'b1;
        else if (!w_wr && w_rd) r_level <= r_level - 1'b1;
      end
    end
  end

  assign bus.data           = w_nempty ? w_head[MAX_WORD_LEN-1:0] : '0;
  assign bus.rx_frameerror  = w_nempty & w_head[MAX_WORD_LEN];
  assign bus.rx_parityerror = w_nempty & w_head[MAX_WORD_LEN+1];
  assign bus.rx_break       = w_nempty & w_head[MAX_WORD_LEN+2];
  assign bus.charreceived   = w_nempty;
  assign bus.full           = w_full;
  assign bus.level          = r_level;
  assign bus.receiveoverrun = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: framing, errors, FIFO limits,
// glitch rejection, break and mid-frame reset.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rxen;
  logic       rx;
  logic [3:0] wordlen;
  logic [1:0] parity;
  logic       stopbits;
  logic       u2x;
  logic       busy;
  int         n_checks;
  int         n_errors;
  int         tcnt;

  uart_rx_fifo_if #(.MAX_WORD_LEN(9), .FIFO_DEPTH(16)) bus ();

  uart_rx_fifo #(
    .MAX_WORD_LEN(9),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .baud_tick(baud_tick),
    .rxen(rxen),
    .rx(rx),
    .wordlen(wordlen),
    .parity(parity),
    .stopbits(stopbits),
    .u2x(u2x),
    .busy(busy),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One baud tick every 4 clks
  initial begin
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = tcnt + 1;
      baud_tick = (tcnt % 4 == 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_tick();
    do @(posedge clk); while (!baud_tick);
  endtask

  task automatic pop();
    @(negedge clk) bus.rd = 1'b1;
    @(negedge clk) bus.rd = 1'b0;
  endtask

  task automatic pulse_flush();
    @(negedge clk) bus.flush = 1'b1;
    @(negedge clk) bus.flush = 1'b0;
  endtask

  task automatic pulse_ovr_clr();
    @(negedge clk) bus.ovr_clr = 1'b1;
    @(negedge clk) bus.ovr_clr = 1'b0;
  endtask

  // Sends one frame plus one idle bit; rd_at >= 0 raises rd
  // for one clk at that negedge index (0 = start bit edge).
  task automatic send_frame(input logic [8:0] d, input int wl,
                            input int par, input bit badpar,
                            input int nstop, input bit s2,
                            input int os, input int rd_at);
    logic [15:0] fb;
    logic        p;
    int          nb;
    int          k;
    fb = '0;
    p = 1'b0;
    fb[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < wl; i++) begin
      fb[nb] = d[i];
      p = p ^ d[i];
      nb++;
    end
    if (par == 1 || par == 2) begin
      if (par == 2) p = ~p;
      if (badpar) p = ~p;
      fb[nb] = p;
      nb++;
    end
    fb[nb] = 1'b1;
    nb++;
    if (nstop == 2) begin
      fb[nb] = s2;
      nb++;
    end
    fb[nb] = 1'b1;
    nb++;
    align_tick();
    k = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < os * 4; c++) begin
        @(negedge clk);
        rx = fb[b];
        bus.rd = (k == rd_at);
        k++;
      end
    end
    bus.rd = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    rx = 1'b1;
    rxen = 1'b1;
    wordlen = 4'd8;
    parity = 2'd0;
    stopbits = 1'b0;
    u2x = 1'b0;
    bus.rd = 1'b0;
    bus.flush = 1'b0;
    bus.ovr_clr = 1'b0;
    wait_clks(4);
    check("rst_level", 32'(bus.level), 0);
    check("rst_charrx", 32'(bus.charreceived), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_ovr", 32'(bus.receiveoverrun), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(bus.data), 0);
    rst = 1'b1;
    wait_clks(8);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, 16, -1);
    check("8n1_data", 32'(bus.data), 32'h0A5);
    check("8n1_charrx", 32'(bus.charreceived), 1);
    check("8n1_level", 32'(bus.level), 1);
    check("8n1_ferr", 32'(bus.rx_frameerror), 0);
    check("8n1_perr", 32'(bus.rx_parityerror), 0);
    check("8n1_brk", 32'(bus.rx_break), 0);
    pop();
    check("8n1_pop_charrx", 32'(bus.charreceived), 0);
    check("8n1_pop_level", 32'(bus.level), 0);

    // 7E2 with bad parity, then good parity and bad 2nd stop
    wordlen = 4'd7;
    parity = 2'd1;
    stopbits = 1'b1;
    send_frame(9'h035, 7, 1, 1'b1, 2, 1'b1, 16, -1);
    check("7e2_data", 32'(bus.data), 32'h35);
    check("7e2_perr", 32'(bus.rx_parityerror), 1);
    check("7e2_ferr", 32'(bus.rx_frameerror), 0);
    pop();
    send_frame(9'h035, 7, 1, 1'b0, 2, 1'b0, 16, -1);
    check("7e2s_data", 32'(bus.data), 32'h35);
    check("7e2s_perr", 32'(bus.rx_parityerror), 0);
    check("7e2s_ferr", 32'(bus.rx_frameerror), 1);
    pop();

    // Start-bit glitch: low for 4 ticks
    wordlen = 4'd8;
    parity = 2'd0;
    stopbits = 1'b0;
    align_tick();
    @(negedge clk) rx = 1'b0;
    wait_clks(15);
    @(negedge clk) rx = 1'b1;
    wait_clks(8);
    check("glitch_busy_hi", 32'(busy), 1);
    wait_clks(64);
    check("glitch_busy_lo", 32'(busy), 0);
    check("glitch_level", 32'(bus.level), 0);

    // Fill beyond depth, overrun, clear, coincident push+pop
    pulse_flush();
    for (int i = 0; i < 17; i++)
      send_frame(9'(i), 8, 0, 1'b0, 1, 1'b1, 16, -1);
    check("ovf_full", 32'(bus.full), 1);
    check("ovf_level", 32'(bus.level), 16);
    check("ovf_ovr", 32'(bus.receiveoverrun), 1);
    check("ovf_head", 32'(bus.data), 0);
    pulse_ovr_clr();
    check("ovr_clr", 32'(bus.receiveoverrun), 0);
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1, 16, 615);
    check("coinc_ovr", 32'(bus.receiveoverrun), 0);
    check("coinc_level", 32'(bus.level), 16);
    check("coinc_full", 32'(bus.full), 1);
    for (int i = 1; i < 16; i++) begin
      check("fifo_pop", 32'(bus.data), 32'(i));
      pop();
    end
    check("fifo_last", 32'(bus.data), 32'h11);
    pop();
    check("fifo_empty", 32'(bus.charreceived), 0);

    // Break: line low for 12 bit times
    align_tick();
    @(negedge clk) rx = 1'b0;
    wait_clks(12 * 64 - 1);
    @(negedge clk) rx = 1'b1;
    wait_clks(128);
    check("brk_level", 32'(bus.level), 1);
    check("brk_data", 32'(bus.data), 0);
    check("brk_flag", 32'(bus.rx_break), 1);
    check("brk_ferr", 32'(bus.rx_frameerror), 1);
    pop();
    send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1, 16, -1);
    check("post_brk_level", 32'(bus.level), 1);
    check("post_brk_data", 32'(bus.data), 32'h5A);
    check("post_brk_flag", 32'(bus.rx_break), 0);
    check("post_brk_ferr", 32'(bus.rx_frameerror), 0);
    pop();

    // 9O1 double speed, then reset mid-frame
    wordlen = 4'd9;
    parity = 2'd2;
    stopbits = 1'b0;
    u2x = 1'b1;
    send_frame(9'h1FF, 9, 2, 1'b0, 1, 1'b1, 8, -1);
    check("9o1_level", 32'(bus.level), 1);
    check("9o1_data", 32'(bus.data), 32'h1FF);
    check("9o1_perr", 32'(bus.rx_parityerror), 0);
    check("9o1_ferr", 32'(bus.rx_frameerror), 0);
    check("9o1_brk", 32'(bus.rx_break), 0);
    align_tick();
    @(negedge clk) rx = 1'b0;
    wait_clks(31);
    @(negedge clk) rx = 1'b1;
    wait_clks(63);
    check("mid_busy", 32'(busy), 1);
    @(negedge clk) rst = 1'b0;
    wait_clks(2);
    @(negedge clk) rst = 1'b1;
    check("mrst_level", 32'(bus.level), 0);
    check("mrst_busy", 32'(busy), 0);
    wait_clks(640);
    check("mrst_nopush", 32'(bus.level), 0);
    check("mrst_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
